// File: rtl/l1_fill_engine_if.sv
// Port bundle for the L1 line-fill sequencer: miss-logic handshake, memory read
// channel and datastore port-B write channel. master = fill engine, slave = surroundings.
interface l1_fill_engine_if #(
  parameter int addr_width      = 10,
  parameter int line_words_log2 = 3
);
  logic                                    fill_req;
  logic [addr_width-line_words_log2-1:0]   fill_line;
  logic [line_words_log2-1:0]              fill_word;
  logic                                    fill_busy;
  logic                                    fill_done;

  logic                                    mem_rd_req;
  logic [addr_width-1:0]                   mem_rd_addr;
  logic                                    mem_rd_ack;
  logic                                    mem_data_valid;
  logic [31:0]                             mem_data;

  logic [addr_width-1:0]                   ds_addr_b;
  logic [31:0]                             ds_data_b;
  logic [3:0]                              ds_byte_enable_b;
  logic                                    ds_wr_b;

  modport master (
    input  fill_req, fill_line, fill_word,
    input  mem_rd_ack, mem_data_valid, mem_data,
    output fill_busy, fill_done,
    output mem_rd_req, mem_rd_addr,
    output ds_addr_b, ds_data_b, ds_byte_enable_b, ds_wr_b
  );

  modport slave (
    output fill_req, fill_line, fill_word,
    output mem_rd_ack, mem_data_valid, mem_data,
    input  fill_busy, fill_done,
    input  mem_rd_req, mem_rd_addr,
    input  ds_addr_b, ds_data_b, ds_byte_enable_b, ds_wr_b
  );
endinterface

// File: rtl/l1_fill_engine.sv
// L1 data-cache line-fill sequencer: requests one line, writes each returned beat to
// datastore port B. Define L1_FILL_CRITICAL_WORD_FIRST_EN to start at the critical word.
module l1_fill_engine #(
  parameter int addr_width      = 10,
  parameter int line_words_log2 = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  l1_fill_engine_if.master bus
);

  localparam int LINE_W = addr_width - line_words_log2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;

  logic [LINE_W-1:0]          r_line;
  logic [line_words_log2-1:0] r_start;
  logic [line_words_log2-1:0] r_count;
  logic [line_words_log2-1:0] w_start;
  logic [line_words_log2-1:0] w_offset;

  logic                       w_accept;
  logic                       w_beat;
  logic                       w_last_beat;

  logic                       r_fill_busy;
  logic                       r_fill_done;
  logic                       r_mem_rd_req;
  logic [addr_width-1:0]      r_mem_rd_addr;
  logic [addr_width-1:0]      r_ds_addr_b;
  logic [31:0]                r_ds_data_b;
  logic                       r_ds_wr_b;

  logic                       w_fill_busy_next;
  logic                       w_fill_done_next;
  logic                       w_mem_rd_req_next;
  logic [addr_width-1:0]      w_mem_rd_addr_next;
  logic [addr_width-1:0]      w_ds_addr_b_next;
  logic [31:0]                w_ds_data_b_next;
  logic                       w_ds_wr_b_next;

`ifdef L1_FILL_CRITICAL_WORD_FIRST_EN
  assign w_start = bus.fill_word;
`else
  logic w_unused_fill_word;
  assign w_start            = '0;
  assign w_unused_fill_word = ^bus.fill_word;
`endif

  assign w_accept    = (r_state == S_IDLE) && bus.fill_req;
  assign w_beat      = (r_state == S_DATA) && bus.mem_data_valid;
  assign w_last_beat = w_beat && (r_count == {line_words_log2{1'b1}});
  // Offset wraps within the line, so a critical-word start walks round to word 0.
  assign w_offset    = r_start + r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.fill_req)    w_state_next = S_REQ;
      S_REQ:   if (bus.mem_rd_ack)  w_state_next = S_DATA;
      S_DATA:  if (w_last_beat)     w_state_next = S_DONE;
      S_DONE:                       w_state_next = S_IDLE;
      default:                      w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_fill_busy_next   = (w_state_next != S_IDLE);
    w_mem_rd_req_next  = (w_state_next == S_REQ);
    w_fill_done_next   = w_last_beat;
    w_ds_wr_b_next     = w_beat;
    w_mem_rd_addr_next = r_mem_rd_addr;
    w_ds_addr_b_next   = r_ds_addr_b;
    w_ds_data_b_next   = r_ds_data_b;
    if (w_accept) begin
      w_mem_rd_addr_next = {bus.fill_line, w_start};
    end
    if (w_beat) begin
      w_ds_addr_b_next = {r_line, w_offset};
      w_ds_data_b_next = bus.mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line  <= '0;
      r_start <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_line  <= bus.fill_line;
      r_start <= w_start;
      r_count <= '0;
    end else if (w_beat) begin
      r_count <= r_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill_busy   <= 1'b0;
      r_fill_done   <= 1'b0;
      r_mem_rd_req  <= 1'b0;
      r_mem_rd_addr <= '0;
      r_ds_addr_b   <= '0;
      r_ds_data_b   <= '0;
      r_ds_wr_b     <= 1'b0;
    end else begin
      r_fill_busy   <= w_fill_busy_next;
      r_fill_done   <= w_fill_done_next;
      r_mem_rd_req  <= w_mem_rd_req_next;
      r_mem_rd_addr <= w_mem_rd_addr_next;
      r_ds_addr_b   <= w_ds_addr_b_next;
      r_ds_data_b   <= w_ds_data_b_next;
      r_ds_wr_b     <= w_ds_wr_b_next;
    end
  end

  assign bus.fill_busy   = r_fill_busy;
  assign bus.fill_done   = r_fill_done;
  assign bus.mem_rd_req  = r_mem_rd_req;
  assign bus.mem_rd_addr = r_mem_rd_addr;
  assign bus.ds_addr_b   = r_ds_addr_b;
  assign bus.ds_data_b   = r_ds_data_b;
  assign bus.ds_wr_b     = r_ds_wr_b;

  // Fills always write whole words.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte_en
      assign bus.ds_byte_enable_b[gi] = 1'b1;
    end
  endgenerate

endmodule

// File: tb/tb_l1_fill_engine.sv
// Scoreboard bench for l1_fill_engine: expected datastore writes are queued when a fill
// starts and popped by a monitor on every port-B write.
module tb_l1_fill_engine;

  logic clk;
  logic rst_n;

  l1_fill_engine_if #(.addr_width(10), .line_words_log2(3)) bus ();

  l1_fill_engine #(.addr_width(10), .line_words_log2(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    logic        done;
  } wr_t;

  wr_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.ds_wr_b) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(bus.ds_wr_b), 64'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        $display("[TB] write addr=0x%03h data=0x%08h done=%0b", bus.ds_addr_b, bus.ds_data_b, bus.fill_done);
        check("wr_addr", 64'(bus.ds_addr_b), 64'(e.addr));
        check("wr_data", 64'(bus.ds_data_b), 64'(e.data));
        check("wr_done", 64'(bus.fill_done), 64'(e.done));
        check("wr_byte_en", 64'(bus.ds_byte_enable_b), 64'hF);
      end
    end
    if (bus.fill_done && !bus.ds_wr_b) begin
      check("done_without_write", 64'(bus.fill_done), 64'd0);
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   64'(bus.fill_busy),        64'd0);
    check({tag, "_done"},   64'(bus.fill_done),        64'd0);
    check({tag, "_rdreq"},  64'(bus.mem_rd_req),       64'd0);
    check({tag, "_rdaddr"}, 64'(bus.mem_rd_addr),      64'd0);
    check({tag, "_dsaddr"}, 64'(bus.ds_addr_b),        64'd0);
    check({tag, "_dsdata"}, 64'(bus.ds_data_b),        64'd0);
    check({tag, "_dswr"},   64'(bus.ds_wr_b),          64'd0);
    check({tag, "_be"},     64'(bus.ds_byte_enable_b), 64'hF);
  endtask

  // Called at a negedge; returns at the first IDLE negedge after DONE, or right after
  // the write of beat abort_after when abort_after is non-zero.
  task automatic do_fill(input logic [6:0] line, input logic [2:0] word, input int ack_delay,
                         input int gap, input bit junk_in_ack, input bit req_in_data,
                         input logic [31:0] base, input int abort_after);
    logic [2:0] start;
    logic [2:0] off;
    logic [9:0] exp_addr;
    int         n_beats;
    wr_t        e;
`ifdef L1_FILL_CRITICAL_WORD_FIRST_EN
    start = word;
`else
    start = 3'd0;
`endif
    n_beats = (abort_after > 0) ? abort_after : 8;
    $display("[TB] fill line=0x%02h word=%0d ack_delay=%0d gap=%0d", line, word, ack_delay, gap);

    bus.fill_req  = 1'b1;
    bus.fill_line = line;
    bus.fill_word = word;
    for (int i = 0; i < 8; i++) begin
      off    = start + 3'(i);
      e.addr = {line, off};
      e.data = base + 32'(i);
      e.done = (i == 7);
      exp_q.push_back(e);
    end

    @(negedge clk);
    bus.fill_req  = 1'b0;
    bus.fill_line = ~line;
    bus.fill_word = ~word;
    exp_addr = {line, start};
    check("req_busy",   64'(bus.fill_busy),   64'd1);
    check("req_rdreq",  64'(bus.mem_rd_req),  64'd1);
    check("req_rdaddr", 64'(bus.mem_rd_addr), 64'(exp_addr));

    for (int i = 0; i < ack_delay; i++) begin
      @(negedge clk);
      check("rdreq_held", 64'(bus.mem_rd_req), 64'd1);
    end
    bus.mem_rd_ack = 1'b1;
    if (junk_in_ack) begin
      bus.mem_data_valid = 1'b1;
      bus.mem_data       = 32'hDEAD_BEEF;
    end

    @(negedge clk);
    bus.mem_rd_ack     = 1'b0;
    bus.mem_data_valid = 1'b0;
    check("rdreq_drop", 64'(bus.mem_rd_req), 64'd0);
    check("data_busy",  64'(bus.fill_busy),  64'd1);

    for (int i = 0; i < n_beats; i++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check("gap_busy", 64'(bus.fill_busy), 64'd1);
      end
      bus.mem_data_valid = 1'b1;
      bus.mem_data       = base + 32'(i);
      if (req_in_data && i == 3) begin
        bus.fill_req  = 1'b1;
        bus.fill_line = 7'h7F;
      end
      @(negedge clk);
      bus.mem_data_valid = 1'b0;
      bus.fill_req       = 1'b0;
      check("beat_busy",  64'(bus.fill_busy),  64'd1);
      check("beat_rdreq", 64'(bus.mem_rd_req), 64'd0);
    end
    if (abort_after > 0) return;

    check("done_pulse", 64'(bus.fill_done), 64'd1);
    @(negedge clk);
    check("idle_busy", 64'(bus.fill_busy), 64'd0);
    check("idle_done", 64'(bus.fill_done), 64'd0);
    check("idle_wr",   64'(bus.ds_wr_b),   64'd0);
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.fill_req       = 1'b0;
    bus.fill_line      = '0;
    bus.fill_word      = '0;
    bus.mem_rd_ack     = 1'b0;
    bus.mem_data_valid = 1'b0;
    bus.mem_data       = '0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    do_fill(7'h05, 3'd0, 2, 0, 1'b1, 1'b0, 32'hA0, 0);
    @(negedge clk);
    do_fill(7'h12, 3'd0, 0, 2, 1'b0, 1'b1, 32'hB0, 0);
    @(negedge clk);
    do_fill(7'h05, 3'd5, 1, 0, 1'b0, 1'b0, 32'hC0, 0);
    do_fill(7'h21, 3'd3, 0, 1, 1'b0, 1'b0, 32'hD0, 0);

    @(negedge clk);
    do_fill(7'h33, 3'd2, 0, 0, 1'b0, 1'b0, 32'hE0, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("[TB] reset asserted mid-fill");
    check_reset_outputs("midreset");
    check("abandoned_beats", 64'(exp_q.size()), 64'd5);
    exp_q.delete();
    repeat (2) begin
      @(negedge clk);
      check("rst_busy", 64'(bus.fill_busy), 64'd0);
      check("rst_done", 64'(bus.fill_done), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    do_fill(7'h05, 3'd7, 0, 0, 1'b0, 1'b0, 32'hF0, 0);

    @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/l1_fill_engine.md
# l1_fill_engine

Line-fill sequencer for the L1 data cache. On a miss it requests one cache line from the memory side, accepts the returned 32-bit beats, and writes each beat into port B of the L1 dual-port datastore RAM with full byte enables. It sits between the miss/tag logic, which issues fill requests and consumes completion, and the datastore, whose port B it owns exclusively.

## Interface
- `addr_width`, 10, datastore word-address width; matches the datastore instance.
- `line_words_log2`, 3, log2 of words per line (default 8 words); must be ≥1 and < `addr_width`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fill_req`  in  1  one-cycle pulse; start a fill; honoured only in IDLE.
- `fill_line`  in  `addr_width-line_words_log2`  line index, sampled with `fill_req`.
- `fill_word`  in  `line_words_log2`  critical word offset, sampled with `fill_req`; used only under the configuration macro.
- `fill_busy`  out  1  high in REQ, DATA and DONE.
- `fill_done`  out  1  one-cycle pulse marking the final datastore write.
- `mem_rd_req`  out  1  read request, held until acknowledged.
- `mem_rd_addr`  out  `addr_width`  word address of the first beat.
- `mem_rd_ack`  in  1  request accepted.
- `mem_data_valid`  in  1  beat present on `mem_data`.
- `mem_data`  in  32  beat data.
- `ds_addr_b`  out  `addr_width`  datastore port-B address.
- `ds_data_b`  out  32  datastore port-B write data.
- `ds_byte_enable_b`  out  4  fixed 4'b1111.
- `ds_wr_b`  out  1  datastore port-B write strobe.

## Operation
- States: IDLE, REQ, DATA, DONE.
- IDLE: `fill_req`=1 captures `fill_line` and the start offset, which is `fill_word` with the macro and 0 without it. It also clears the beat counter and goes to REQ. `fill_req` in any other state is ignored.
- REQ: `mem_rd_req`=1 and `mem_rd_addr`={line, start offset}. `mem_rd_ack`=1 moves to DATA.
- DATA: each cycle with `mem_data_valid`=1 accepts one beat.
  - The beat writes to `ds_addr_b` = {line, (start + count) mod 2^`line_words_log2`}.
  - The counter is `line_words_log2` bits wide and increments per beat.
  - The beat that brings the count to 2^`line_words_log2` moves the state to DONE.
- DONE: lasts exactly one cycle, then returns to IDLE.
- Beats with `mem_data_valid`=1 outside DATA are ignored. This includes a beat in the same cycle as `mem_rd_ack`. Memory never sends the first beat before the cycle after ack.
- The in-line offset wraps modulo line size. The line index never changes during a fill.
- Assertion of `rst_n` at any time forces IDLE and abandons the fill. No partial-line cleanup is done; the tag logic must not validate the line.

## Timing
- All outputs are registered. Reset values: `fill_busy`=0, `fill_done`=0, `mem_rd_req`=0, `mem_rd_addr`=0, `ds_addr_b`=0, `ds_data_b`=0, `ds_wr_b`=0. `ds_byte_enable_b` is 4'b1111 always, including in reset.
- `fill_req` sampled at edge N: `fill_busy` and `mem_rd_req` are high from cycle N+1.
- `mem_rd_ack` sampled at edge M: `mem_rd_req` is low from M+1.
- Beat sampled at edge K: `ds_wr_b`=1 with its address and data during cycle K+1 only. Latency is 1 cycle, with no buffering or back-pressure, so every beat is absorbed.
- Last beat at edge L: `ds_wr_b`=1 and `fill_done`=1 in cycle L+1 (DONE state). `fill_busy` is low from L+2, and a new `fill_req` is accepted at edge L+2 at the earliest.
- Minimum fill length: 1 (req) + 2^`line_words_log2` + 1 (DONE) cycles, assuming ack in the first REQ cycle and back-to-back beats.

## Configuration
- `L1_FILL_CRITICAL_WORD_FIRST_EN` defined:
  - start offset = `fill_word`;
  - `mem_rd_addr` low bits = `fill_word`;
  - datastore addresses wrap through the line starting at the critical word.
- Undefined:
  - `fill_word` is unused;
  - start offset is 0, so `mem_rd_addr` is line-aligned;
  - writes are strictly ascending from word 0.

## Test plan
- Basic fill: default parameters, `fill_line`=7'h05, ack after 2 cycles, 8 back-to-back beats 0xA0..0xA7. Expected: writes to addresses 0x028..0x02F with data 0xA0..0xA7, then one `fill_done` pulse on the write to 0x02F.
- Gapped beats: invalid cycles between each beat. Expected: exactly 8 writes, one per valid beat; `fill_busy` stays high throughout; `fill_done` occurs only on the 8th write.
- Critical word first (macro on): `fill_line`=7'h05, `fill_word`=5. Expected: `mem_rd_addr`=0x02D; writes go to 0x02D, 0x02E, 0x02F, 0x028 … 0x02C in that order.
- Ignored events:
  - `fill_req` pulsed during DATA: no effect, and `fill_line` is unchanged;
  - `mem_data_valid` in the ack cycle: no write is issued.
- Reset mid-fill: `rst_n` pulled low after 3 beats. Expected: all outputs return to reset values immediately and no `fill_done` is issued; a subsequent fill runs normally.
- Back-to-back fills: `fill_req` at the first IDLE cycle after DONE. Expected: accepted, and `mem_rd_req` is high in the following cycle.
